// File: rtl/dec_syndrome.sv
// RS decoder front end: accumulates the RS_PAR_LEN syndromes S_j = c(alpha^j) of one
// codeword with a per-beat Horner chain, then offers them downstream via valid/ready.
module dec_syndrome #(
   parameter int                   EGF_ORDER   = 8,
   parameter logic [EGF_ORDER-1:0] EGF_PRI_POL = 8'h1D,
   parameter int                   RS_MES_LEN  = 239,
   parameter int                   RS_PAR_LEN  = 16,
   parameter int                   DEC_SYM_NUM = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [DEC_SYM_NUM*EGF_ORDER-1:0]  in_data,
   output logic                              syn_valid,
   input  logic                              syn_ready,
   output logic [RS_PAR_LEN*EGF_ORDER-1:0]   syn_data,
   output logic                              syn_zero
);

   // Handshakes: a beat moves when in_valid && in_ready; the syndrome vector moves
   // when syn_valid && syn_ready, and stays stable while syn_valid is high.

   localparam int N_LEN = RS_MES_LEN + RS_PAR_LEN;
   localparam int H_LEN = N_LEN % DEC_SYM_NUM;
   localparam int B_NUM = (N_LEN + DEC_SYM_NUM - 1) / DEC_SYM_NUM;
   localparam int CW    = $clog2(B_NUM + 1);

   localparam logic [CW-1:0] LAST_CNT = CW'(B_NUM - 1);

   localparam logic [1:0] SYN_HAL = 2'd0;
   localparam logic [1:0] SYN_FUL = 2'd1;
   localparam logic [1:0] SYN_OUT = 2'd2;

   function automatic logic [EGF_ORDER-1:0] gf_mul(input logic [EGF_ORDER-1:0] a,
                                                   input logic [EGF_ORDER-1:0] b);
      logic [EGF_ORDER-1:0] p;
      logic [EGF_ORDER-1:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < EGF_ORDER; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[EGF_ORDER-2:0], 1'b0} ^ (x[EGF_ORDER-1] ? EGF_PRI_POL : '0);
      end
      return p;
   endfunction

   function automatic logic [EGF_ORDER-1:0] alpha_pow(input int j);
      logic [EGF_ORDER-1:0] p;
      p = EGF_ORDER'(1);
      for (int i = 0; i < j; i++) p = gf_mul(p, EGF_ORDER'(2));
      return p;
   endfunction

   function automatic logic [DEC_SYM_NUM-1:0] half_mask();
      logic [DEC_SYM_NUM-1:0] m;
      for (int k = 0; k < DEC_SYM_NUM; k++) m[k] = (H_LEN == 0) || (k < H_LEN);
      return m;
   endfunction

   // Lane DEC_SYM_NUM-1 is the earliest symbol, so the chain runs from the top lane down.
   function automatic logic [EGF_ORDER-1:0] horner(input logic [EGF_ORDER-1:0]             acc_in,
                                                   input logic [DEC_SYM_NUM*EGF_ORDER-1:0] data,
                                                   input logic [DEC_SYM_NUM-1:0]           en,
                                                   input logic [EGF_ORDER-1:0]             coef);
      logic [EGF_ORDER-1:0] acc;
      acc = acc_in;
      for (int k = DEC_SYM_NUM - 1; k >= 0; k--) begin
         if (en[k]) acc = gf_mul(acc, coef) ^ data[k*EGF_ORDER +: EGF_ORDER];
      end
      return acc;
   endfunction

   localparam logic [DEC_SYM_NUM-1:0] HALF_MASK = half_mask();

   logic [1:0]                                 state_q, state_d;
   logic [CW-1:0]                              cnt_q, cnt_d;
   logic [RS_PAR_LEN-1:0][EGF_ORDER-1:0]       syn_q, syn_d;
   logic                                       zero_q, zero_d;
   logic                                       load;
   logic                                       hal;
   logic [DEC_SYM_NUM-1:0]                     lane_en;

   assign hal     = (state_q == SYN_HAL);
   assign lane_en = hal ? HALF_MASK : '1;

   // Beat 0 starts from a zero accumulator, so unused upper lanes of a half beat are skipped.
   for (genvar j = 0; j < RS_PAR_LEN; j++) begin : g_syn
      localparam logic [EGF_ORDER-1:0] COEF = alpha_pow(j);
      assign syn_d[j] = horner(hal ? '0 : syn_q[j], in_data, lane_en, COEF);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      zero_d  = zero_q;
      load    = 1'b0;
      case (state_q)
         SYN_HAL: begin
            if (in_valid) begin
               load  = 1'b1;
               cnt_d = CW'(1);
               if (B_NUM == 1) begin
                  state_d = SYN_OUT;
                  zero_d  = ~|syn_d;
               end else begin
                  state_d = SYN_FUL;
               end
            end
         end
         SYN_FUL: begin
            if (in_valid) begin
               load  = 1'b1;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_CNT) begin
                  state_d = SYN_OUT;
                  zero_d  = ~|syn_d;
               end
            end
         end
         SYN_OUT: begin
            if (syn_ready) begin
               state_d = SYN_HAL;
               cnt_d   = '0;
               zero_d  = 1'b0;
            end
         end
         default: begin
            state_d = SYN_HAL;
            cnt_d   = '0;
            zero_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SYN_HAL;
         cnt_q   <= '0;
         syn_q   <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         zero_q  <= zero_d;
         if (load) syn_q <= syn_d;
      end
   end

   assign in_ready  = (state_q != SYN_OUT);
   assign syn_valid = (state_q == SYN_OUT);
   assign syn_data  = syn_q;
   assign syn_zero  = zero_q;

endmodule

// File: tb/tb_dec_syndrome.sv
// Self-checking bench for dec_syndrome: codewords built in a degree-indexed array,
// syndromes predicted by direct polynomial evaluation with GF log/antilog tables.
module tb_dec_syndrome;

   localparam int M = 8;
   localparam int D = 4;
   localparam int P = 16;
   localparam int K = 239;
   localparam int N = K + P;
   localparam int H = N % D;
   localparam int B = (N + D - 1) / D;

   logic           clk;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [D*M-1:0] in_data;
   logic           syn_valid;
   logic           syn_ready;
   logic [P*M-1:0] syn_data;
   logic           syn_zero;

   dec_syndrome #(
      .EGF_ORDER   (M),
      .EGF_PRI_POL (8'h1D),
      .RS_MES_LEN  (K),
      .RS_PAR_LEN  (P),
      .DEC_SYM_NUM (D)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .syn_valid (syn_valid),
      .syn_ready (syn_ready),
      .syn_data  (syn_data),
      .syn_zero  (syn_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_t [255];
   int         log_t [256];
   logic [7:0] cw    [N];
   logic [7:0] exp_syn [P];
   logic [7:0] gen   [P+1];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      if (a == 8'h00 || b == 8'h00) return 8'h00;
      return exp_t[(log_t[a] + log_t[b]) % 255];
   endfunction

   task automatic build_tables();
      logic [8:0] x;
      x = 9'h001;
      for (int i = 0; i < 255; i++) begin
         exp_t[i] = x[7:0];
         log_t[x[7:0]] = i;
         x = x << 1;
         if (x[8]) x = x ^ 9'h11D;
      end
   endtask

   // g(x) = prod_{j=0}^{P-1} (x + alpha^j), coefficients by degree.
   task automatic build_gen();
      for (int i = 0; i <= P; i++) gen[i] = 8'h00;
      gen[0] = 8'h01;
      for (int j = 0; j < P; j++) begin
         for (int i = P; i >= 1; i--) gen[i] = gen[i-1] ^ gmul(gen[i], exp_t[j]);
         gen[0] = gmul(gen[0], exp_t[j]);
      end
   endtask

   task automatic encode_random();
      logic [7:0] rem [P];
      logic [7:0] fb;
      for (int i = 0; i < P; i++) rem[i] = 8'h00;
      for (int d = N - 1; d >= P; d--) cw[d] = 8'($urandom);
      for (int d = N - 1; d >= P; d--) begin
         fb = cw[d] ^ rem[P-1];
         for (int i = P - 1; i >= 1; i--) rem[i] = rem[i-1] ^ gmul(fb, gen[i]);
         rem[0] = gmul(fb, gen[0]);
      end
      for (int i = 0; i < P; i++) cw[i] = rem[i];
   endtask

   task automatic fill_cw(input int mode);
      for (int i = 0; i < N; i++) cw[i] = (mode == 0) ? 8'h00 : 8'($urandom);
   endtask

   task automatic compute_model();
      logic [7:0] s;
      for (int j = 0; j < P; j++) begin
         s = 8'h00;
         for (int i = 0; i < N; i++) s ^= gmul(cw[i], exp_t[(j * i) % 255]);
         exp_syn[j] = s;
      end
   endtask

   function automatic logic [P*M-1:0] exp_vec();
      logic [P*M-1:0] v;
      for (int j = 0; j < P; j++) v[j*M +: M] = exp_syn[j];
      return v;
   endfunction

   function automatic logic exp_all_zero();
      logic z;
      z = 1'b1;
      for (int j = 0; j < P; j++) if (exp_syn[j] != 8'h00) z = 1'b0;
      return z;
   endfunction

   // Arrival order is degree N-1 first; beat 0 carries H symbols when H != 0.
   function automatic logic [D*M-1:0] make_beat(input int b);
      logic [D*M-1:0] d;
      int a;
      d = '0;
      for (int k = 0; k < D; k++) begin
         if (b == 0 && H != 0) begin
            if (k < H) d[k*M +: M] = cw[N-H+k];
            else       d[k*M +: M] = 8'($urandom);
         end else begin
            a = ((H == 0) ? b * D : H + (b - 1) * D) + (D - 1 - k);
            d[k*M +: M] = cw[N-1-a];
         end
      end
      return d;
   endfunction

   task automatic check(input string tag, input logic [P*M-1:0] obs, input logic [P*M-1:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Called at a negedge; returns at the negedge after the beat was accepted.
   task automatic send_beat(input logic [D*M-1:0] d);
      int guard;
      guard = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) check("in_ready_timeout", '0, 1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_codeword(input bit gaps);
      for (int b = 0; b < B; b++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
         if (b == B - 1) check("valid_before_last", syn_valid, 0);
         send_beat(make_beat(b));
      end
   endtask

   task automatic check_syn(input string tag);
      check({tag, " valid"}, syn_valid, 1);
      check({tag, " in_ready"}, in_ready, 0);
      for (int j = 0; j < P; j++)
         check($sformatf("%s S%0d", tag, j), syn_data[j*M +: M], exp_syn[j]);
      check({tag, " zero"}, syn_zero, exp_all_zero());
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   int          d_idx [8] = '{0, 1, 2, 3, 7, 8, 9, 15};
   logic [7:0]  d_val [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h80, 8'h1D, 8'h3A, 8'h26};
   logic [P*M-1:0] held;

   initial begin
      build_tables();
      build_gen();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      syn_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst syn_valid", syn_valid, 0);
      check("rst syn_zero", syn_zero, 0);
      check("rst syn_data", syn_data, 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst in_ready", in_ready, 1);

      // All-zero codeword, back-to-back beats; in_ready low for exactly one cycle.
      fill_cw(0);
      compute_model();
      send_codeword(0);
      check_syn("zero_cw");
      check("zero_cw syn_zero", syn_zero, 1);
      @(negedge clk);
      check("zero_cw in_ready_back", in_ready, 1);
      check("zero_cw valid_drop", syn_valid, 0);
      check("zero_cw zero_drop", syn_zero, 0);

      // Single error at degree 0.
      fill_cw(0);
      cw[0] = 8'h01;
      compute_model();
      send_codeword(0);
      check_syn("err_deg0");
      for (int j = 0; j < P; j++)
         check($sformatf("err_deg0 const S%0d", j), syn_data[j*M +: M], 8'h01);
      @(negedge clk);

      // Single error at degree 1.
      fill_cw(0);
      cw[1] = 8'h01;
      compute_model();
      send_codeword(0);
      check_syn("err_deg1");
      for (int i = 0; i < 8; i++)
         check($sformatf("err_deg1 const S%0d", d_idx[i]), syn_data[d_idx[i]*M +: M], d_val[i]);
      @(negedge clk);

      // Encoder-generated codeword, then one message symbol flipped by 5A.
      encode_random();
      compute_model();
      send_codeword(1);
      check_syn("enc_cw");
      check("enc_cw syn_zero", syn_zero, 1);
      @(negedge clk);
      cw[N - 1 - $urandom_range(0, K - 1)] ^= 8'h5A;
      compute_model();
      send_codeword(1);
      check_syn("enc_flip");
      check("enc_flip syn_zero", syn_zero, 0);
      @(negedge clk);

      // Backpressure with junk beats offered while the result is held.
      fill_cw(1);
      compute_model();
      syn_ready = 1'b0;
      send_codeword(0);
      check_syn("bp");
      held = exp_vec();
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1;
         in_data  = D*M'($urandom);
         @(negedge clk);
         check($sformatf("bp hold%0d valid", c), syn_valid, 1);
         check($sformatf("bp hold%0d in_ready", c), in_ready, 0);
         check($sformatf("bp hold%0d data", c), syn_data, held);
      end
      in_valid  = 1'b0;
      syn_ready = 1'b1;
      @(negedge clk);
      check("bp release in_ready", in_ready, 1);
      check("bp release valid", syn_valid, 0);
      send_codeword(1);
      check_syn("bp_gaps");
      @(negedge clk);

      // Random codewords with random gaps.
      for (int r = 0; r < 3; r++) begin
         fill_cw(1);
         compute_model();
         send_codeword(1);
         check_syn($sformatf("rand%0d", r));
         @(negedge clk);
      end

      // Reset after 30 beats of a random codeword.
      fill_cw(1);
      for (int b = 0; b < 30; b++) send_beat(make_beat(b));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst syn_data", syn_data, 0);
      check("midrst syn_valid", syn_valid, 0);
      check("midrst in_ready", in_ready, 1);
      fill_cw(0);
      compute_model();
      send_codeword(0);
      check_syn("midrst_zero");
      check("midrst_zero syn_zero", syn_zero, 1);
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
